rf_32: RTL and testbench
========================

Name: rf_32

Overview:
- 32-entry by 32-bit register file for the MIPS datapath.
- Two read ports, rs → outA and rt → outB, and one write port.
- Sits between instruction decode (register addresses) and the ALU operand inputs / writeback path.
- Writes are synchronous. Reads are registered and qualified by a read enable. Register 0 is hardwired to zero.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports
- ADDR_WIDTH, 5, width of each register address
- DEPTH, 32, number of registers (2**ADDR_WIDTH)

Ports:
- clock  in  1  system clock; all state changes on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- read_enabled  in  1  when high, outA/outB load new read data on the next rising edge
- read_addr_s  in  ADDR_WIDTH  rs read address, drives outA
- read_addr_t  in  ADDR_WIDTH  rt read address, drives outB
- write_enabled  in  1  write strobe
- write_addr  in  ADDR_WIDTH  destination register
- write_data  in  DATA_WIDTH  data to write
- outA  out  DATA_WIDTH  registered read data for read_addr_s
- outB  out  DATA_WIDTH  registered read data for read_addr_t

Behaviour:
- Storage is an array named register_file[0..DEPTH-1], DATA_WIDTH bits each. The name is fixed because benches peek it hierarchically.
- Reset (reset_n low, asynchronous, no clock required):
  - all register_file entries = 0;
  - outA = 0, outB = 0;
  - writes and read captures are blocked while reset_n is low;
  - on deassertion, normal operation begins at the next rising edge.
- Write, at rising edge with write_enabled = 1 and write_addr ≠ 0:
  - register_file[write_addr] ← write_data;
  - the value is visible in register_file from the next timestep.
- Writes to address 0 are discarded. register_file[0] is always 0.
- write_enabled = 0 leaves all entries unchanged.
- Read, at rising edge with read_enabled = 1:
  - outA ← value of read_addr_s; outB ← value of read_addr_t;
  - latency is 1 cycle: the address is presented before the edge and the data is valid after it.
- Read with read_enabled = 0: outA and outB hold their previous values.
- Address 0 always reads 0 on both ports.
- Write-read collision, same edge, with write_enabled = 1, read_enabled = 1, write_addr ≠ 0 and a read address equal to write_addr:
  - that output captures write_data (write-through bypass), not the stale value.
- Both read addresses may be equal; both outputs then return the same value.
- Every address 0..31 is valid; there is no wrap-around or out-of-range case.
- All ports are fully synchronous to clock except reset_n.

Test Plan:
- Reset check: assert reset_n = 0 mid-clock → outA = outB = 0 immediately, all 32 register_file entries = 0. Release, then read every address with read_enabled = 1 → all reads return 0x00000000.
- Fill-and-readback: write addresses 1..31 with distinct patterns (1 → 0x00000000, 2 → 0x11111111, …, 16 → 0xFFFFFFFF, 17..30 → 0x1..0xE, 31 → 0xDEADBEEF), one per cycle.
  - Then sweep read_addr_s 0..31, then read_addr_t 0..31, with read_enabled = 1.
  - Each output matches its written value one cycle after the address is presented.
- Zero register: write 0xDEADBEEF to address 0 → register_file[0] stays 0 and outA reads 0x00000000.
- Read enable hold: load outA = 0x22222222 (address 3), drop read_enabled, change read_addr_s to 5 → outA remains 0x22222222 until read_enabled returns high.
- Bypass: on the same edge write 0xCAFEF00D to address 7 and read read_addr_s = 7, read_addr_t = 7 → outA = outB = 0xCAFEF00D after that edge.
- Write-disable and async reset mid-operation:
  - write_enabled = 0 with write_addr = 9, write_data = 0x12345678 → register 9 is unchanged;
  - then pulse reset_n low between edges while write_enabled = 1 → all registers and outputs clear to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/rf_32.sv
// 32 x 32 register file with two registered read ports and one write port.
// Register 0 reads as zero. A read of the register being written on the same edge returns the new data.
module rf_32 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DEPTH      = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  read_enabled,
  input  logic [ADDR_WIDTH-1:0] read_addr_s,
  input  logic [ADDR_WIDTH-1:0] read_addr_t,
  input  logic                  write_enabled,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] outA,
  output logic [DATA_WIDTH-1:0] outB
);

  logic [DATA_WIDTH-1:0] register_file [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] read_s;
  logic [DATA_WIDTH-1:0] read_t;
  logic                  write_live;

  assign write_live = write_enabled && (write_addr != '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        register_file[i] <= '0;
      end
    end else if (write_live) begin
      register_file[write_addr] <= write_data;
    end
  end

  // Forward the incoming write so a same-edge read never returns stale data.
  always_comb begin
    read_s = register_file[read_addr_s];
    read_t = register_file[read_addr_t];
    if (read_addr_s == '0) begin
      read_s = '0;
    end else if (write_live && (write_addr == read_addr_s)) begin
      read_s = write_data;
    end
    if (read_addr_t == '0) begin
      read_t = '0;
    end else if (write_live && (write_addr == read_addr_t)) begin
      read_t = write_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      outA <= '0;
      outB <= '0;
    end else if (read_enabled) begin
      outA <= read_s;
      outB <= read_t;
    end
  end

endmodule

// File: tb/tb_rf_32.sv
// Directed-vector bench for rf_32: reset, fill/readback, zero register, read hold,
// write-through bypass, write disable and asynchronous reset mid-operation.
module tb_rf_32;

  logic        clock;
  logic        reset_n;
  logic        read_enabled;
  logic [4:0]  read_addr_s;
  logic [4:0]  read_addr_t;
  logic        write_enabled;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [31:0] outA;
  logic [31:0] outB;

  int checks;
  int errors;

  rf_32 #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(32)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .read_enabled (read_enabled),
    .read_addr_s  (read_addr_s),
    .read_addr_t  (read_addr_t),
    .write_enabled(write_enabled),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .outA         (outA),
    .outB         (outB)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Hand-chosen fill pattern for the fill test.
  function automatic logic [31:0] pattern(input int a);
    if (a == 0)       return 32'h0;
    else if (a <= 16) return 32'h11111111 * (a - 1);
    else if (a <= 30) return 32'(a - 16);
    else              return 32'hDEADBEEF;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; read_enabled = 1'b0; read_addr_s = '0; read_addr_t = '0;
    write_enabled = 1'b0; write_addr = '0; write_data = '0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    write_enabled = 1'b1; write_addr = 5'd5; write_data = 32'hA5A5A5A5;
    tick();
    write_enabled = 1'b0; read_enabled = 1'b1; read_addr_s = 5'd5; read_addr_t = 5'd5;
    tick();
    checks++;
    if (outA !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL pre_reset_read: outA=%h expected=%h", outA, 32'hA5A5A5A5);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (outA !== 32'h0 || outB !== 32'h0) begin
      errors++; $display("FAIL reset_outputs: outA=%h outB=%h expected=0", outA, outB);
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (dut.register_file[i] !== 32'h0) begin
        errors++; $display("FAIL reset_reg[%0d]: got=%h expected=0", i, dut.register_file[i]);
      end
    end
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      read_addr_s = 5'(i); read_addr_t = 5'(31 - i);
      tick();
      checks++;
      if (outA !== 32'h0 || outB !== 32'h0) begin
        errors++; $display("FAIL reset_read[%0d]: outA=%h outB=%h expected=0", i, outA, outB);
      end
    end
    read_enabled = 1'b0;
  endtask

  task automatic test_fill_readback();
    for (int a = 1; a < 32; a++) begin
      write_enabled = 1'b1; write_addr = 5'(a); write_data = pattern(a);
      tick();
    end
    write_enabled = 1'b0;
    read_enabled = 1'b1; read_addr_t = '0;
    for (int a = 0; a < 32; a++) begin
      read_addr_s = 5'(a);
      tick();
      checks++;
      if (outA !== pattern(a)) begin
        errors++; $display("FAIL readback_s[%0d]: outA=%h expected=%h", a, outA, pattern(a));
      end
    end
    for (int a = 0; a < 32; a++) begin
      read_addr_t = 5'(a);
      tick();
      checks++;
      if (outB !== pattern(a)) begin
        errors++; $display("FAIL readback_t[%0d]: outB=%h expected=%h", a, outB, pattern(a));
      end
    end
    read_enabled = 1'b0;
  endtask

  task automatic test_zero_reg();
    read_addr_s = 5'd31; read_addr_t = 5'd31; read_enabled = 1'b1;
    tick();
    write_enabled = 1'b1; write_addr = 5'd0; write_data = 32'hDEADBEEF;
    read_addr_s = 5'd0; read_addr_t = 5'd0;
    tick();
    write_enabled = 1'b0;
    checks++;
    if (dut.register_file[0] !== 32'h0) begin
      errors++; $display("FAIL zero_reg_store: got=%h expected=0", dut.register_file[0]);
    end
    checks++;
    if (outA !== 32'h0 || outB !== 32'h0) begin
      errors++; $display("FAIL zero_reg_read: outA=%h outB=%h expected=0", outA, outB);
    end
    read_enabled = 1'b0;
  endtask

  task automatic test_read_hold();
    read_enabled = 1'b1; read_addr_s = 5'd3; read_addr_t = 5'd4;
    tick();
    checks++;
    if (outA !== 32'h22222222) begin
      errors++; $display("FAIL hold_load: outA=%h expected=%h", outA, 32'h22222222);
    end
    read_enabled = 1'b0; read_addr_s = 5'd5; read_addr_t = 5'd6;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (outA !== 32'h22222222 || outB !== 32'h33333333) begin
        errors++; $display("FAIL hold_cycle%0d: outA=%h outB=%h expected=22222222/33333333", i, outA, outB);
      end
    end
    read_enabled = 1'b1;
    tick();
    checks++;
    if (outA !== 32'h44444444 || outB !== 32'h55555555) begin
      errors++; $display("FAIL hold_release: outA=%h outB=%h expected=44444444/55555555", outA, outB);
    end
    read_enabled = 1'b0;
  endtask

  task automatic test_bypass();
    write_enabled = 1'b1; write_addr = 5'd7; write_data = 32'hCAFEF00D;
    read_enabled = 1'b1; read_addr_s = 5'd7; read_addr_t = 5'd7;
    tick();
    checks++;
    if (outA !== 32'hCAFEF00D || outB !== 32'hCAFEF00D) begin
      errors++; $display("FAIL bypass_both: outA=%h outB=%h expected=cafef00d", outA, outB);
    end
    write_addr = 5'd8; write_data = 32'h0BADF00D; read_addr_s = 5'd7; read_addr_t = 5'd8;
    tick();
    write_enabled = 1'b0;
    checks++;
    if (outA !== 32'hCAFEF00D || outB !== 32'h0BADF00D) begin
      errors++; $display("FAIL bypass_one: outA=%h outB=%h expected=cafef00d/0badf00d", outA, outB);
    end
    read_enabled = 1'b0;
  endtask

  task automatic test_write_disable_async_reset();
    write_enabled = 1'b0; write_addr = 5'd9; write_data = 32'h12345678;
    read_enabled = 1'b1; read_addr_s = 5'd9; read_addr_t = 5'd31;
    tick();
    checks++;
    if (dut.register_file[9] !== 32'h88888888 || outA !== 32'h88888888) begin
      errors++; $display("FAIL write_disable: reg9=%h outA=%h expected=88888888", dut.register_file[9], outA);
    end
    write_enabled = 1'b1; write_addr = 5'd10; write_data = 32'h5A5A5A5A;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (outA !== 32'h0 || outB !== 32'h0) begin
      errors++; $display("FAIL async_reset_outputs: outA=%h outB=%h expected=0", outA, outB);
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (dut.register_file[i] !== 32'h0) begin
        errors++; $display("FAIL async_reset_reg[%0d]: got=%h expected=0", i, dut.register_file[i]);
      end
    end
    tick();
    checks++;
    if (dut.register_file[10] !== 32'h0 || outA !== 32'h0 || outB !== 32'h0) begin
      errors++; $display("FAIL reset_blocks_ops: reg10=%h outA=%h outB=%h expected=0", dut.register_file[10], outA, outB);
    end
    reset_n = 1'b1;
    write_enabled = 1'b0; read_addr_s = 5'd10; read_addr_t = 5'd9;
    tick();
    checks++;
    if (outA !== 32'h0 || outB !== 32'h0) begin
      errors++; $display("FAIL post_reset_read: outA=%h outB=%h expected=0", outA, outB);
    end
    read_enabled = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fill_readback();
    test_zero_reg();
    test_read_hold();
    test_bypass();
    test_write_disable_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
